mfp_avalon_arbiter_2to1: RTL and testbench
==========================================

Name: mfp_avalon_arbiter_2to1

Overview:
- Shares the single LPDDR2 Avalon-MM slave port between two Avalon masters: m0 is the CPU memory path from mfp_system, m1 is a secondary master (DMA or debug loader).
- Performs round-robin or fixed-priority arbitration and locks the grant for a whole transaction, including every read beat returned.
- Sits in the avm_clk domain between the masters and lpddr2_wrapper.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8
BURST_WIDTH, 3, burstcount width (maximum burst 2^BURST_WIDTH-1)
FIXED_PRIORITY_M0, 0, 0 = round-robin; 1 = m0 always wins a tie

Ports:
avm_clk  input  1  clock for the whole block
avm_rst  input  1  asynchronous active-high reset
m0_/m1_address  input  ADDR_WIDTH  master address
m0_/m1_byteenable  input  DATA_WIDTH/8  byte enables
m0_/m1_burstcount  input  BURST_WIDTH  burst length; 0 is treated as 1
m0_/m1_writedata  input  DATA_WIDTH  write data
m0_/m1_read, m0_/m1_write  input  1  command strobes
m0_/m1_waitrequest  output  1  stall to master
m0_/m1_readdata  output  DATA_WIDTH  s_readdata broadcast to both masters
m0_/m1_readdatavalid  output  1  s_readdatavalid gated to the granted master
s_address, s_byteenable, s_burstcount, s_writedata  output  as master  forwarded from the granted master
s_read, s_write, s_beginbursttransfer  output  1  slave command strobes
s_waitrequest, s_readdatavalid  input  1  slave handshake
s_readdata  input  DATA_WIDTH  slave read data
grant  output  2  one-hot current owner (bit0 = m0); 00 when idle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (avm_clk, avm_rst).
- Reset values:
  - state IDLE, grant 00, beat counter 0.
  - s_read, s_write, s_beginbursttransfer = 0.
  - m0/m1_waitrequest = 1, m0/m1_readdatavalid = 0.
  - last_grant = m1, so the first tie goes to m0.
- Per-master request: req = read | write.
- waitrequest to a master that is not granted, or is in READ_DATA: always 1.
- Four states: IDLE, WRITE, READ_CMD, READ_DATA.
- IDLE:
  - Single requester: latch grant to it.
  - Both requesting: winner is the master other than last_grant; with FIXED_PRIORITY_M0=1, m0 wins.
  - Next state: WRITE if the winner's write=1 (write beats read if both asserted), else READ_CMD.
  - Arbitration latency is one cycle: a command is never forwarded in the same cycle it is first seen in IDLE.
- Slave outputs:
  - In WRITE and READ_CMD, s_* are combinationally driven from the granted master; the master's waitrequest equals s_waitrequest.
  - In IDLE and READ_DATA, s_read and s_write are 0.
- WRITE:
  - s_beginbursttransfer = 1 on the first beat cycle only, held until that beat is accepted.
  - On the first accepted beat (s_write & !s_waitrequest), counter = max(burstcount,1) - 1.
  - Each later accepted beat decrements the counter.
  - Acceptance with counter 0 after the first beat → IDLE; last_grant updated.
- READ_CMD:
  - s_beginbursttransfer = 1 while the command is pending.
  - On accept (s_read & !s_waitrequest): counter = max(burstcount,1), next state READ_DATA.
- READ_DATA:
  - Granted master's readdatavalid = s_readdatavalid.
  - Each valid beat decrements the counter; the beat that reaches 0 → IDLE; last_grant updated.
  - The master's new commands stall (waitrequest=1) until IDLE.
- s_readdatavalid outside READ_DATA: ignored; never routed to any master.
- Counter width is BURST_WIDTH+1; no wrap is possible.
- A master that drops its strobe before acceptance (protocol violation): the arbiter stays in its state, and the slave sees the strobe drop.
- Reset mid-transaction: immediate return to reset values; outstanding slave beats are discarded, because the slave shares the reset.
- Back-to-back: from IDLE after completion, the other master wins a tie in round-robin mode, so neither can starve while both are requesting.

Test Plan:
- Reset checks: assert avm_rst mid READ_DATA with counter 3 → next edge grant=00, both waitrequest=1, a following s_readdatavalid is not routed.
- Single read: m0 reads burstcount=4 at 0x100, slave waitrequest low 2 cycles later → exactly 1 s_read acceptance with s_beginbursttransfer=1, 4 m0_readdatavalid pulses, m1_readdatavalid stays 0, grant returns to 00 one edge after the 4th beat.
- Tie, round-robin: m0 and m1 both request single writes continuously → grants alternate m0,m1,m0,m1; each write passes through IDLE for 1 cycle.
- Tie, FIXED_PRIORITY_M0=1: same stimulus → m0 granted every time; m1 granted only when m0 is idle.
- Write burst: m1 writes burstcount=3 with s_waitrequest high on beat 2 for 2 cycles → 3 accepted beats with data in order, s_beginbursttransfer only on beat 1, then IDLE.
- burstcount=0 and stray readdatavalid: m0 reads with burstcount=0 → treated as 1 beat; a s_readdatavalid injected in IDLE → no master readdatavalid asserted.

Source files
------------

// File: rtl/mfp_avalon_arbiter_2to1.sv
// Two-master to one-slave Avalon-MM arbiter for the LPDDR2 port; the grant is held for a whole
// transaction, including every read beat, and is released through IDLE.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no owner; arbitrate among requesters, grant takes effect next cycle
// ST_WRITE     | forward write beats from the owner until the burst is complete
// ST_READ_CMD  | forward the owner's read command until the slave accepts it
// ST_READ_DATA | route returning beats to the owner; the owner is stalled meanwhile
module mfp_avalon_arbiter_2to1 #(
   parameter int ADDR_WIDTH        = 32,
   parameter int DATA_WIDTH        = 32,
   parameter int BURST_WIDTH       = 3,
   parameter int FIXED_PRIORITY_M0 = 0
) (
   input  logic                      avm_clk,
   input  logic                      avm_rst,
   input  logic [ADDR_WIDTH-1:0]     m0_address,
   input  logic [DATA_WIDTH/8-1:0]   m0_byteenable,
   input  logic [BURST_WIDTH-1:0]    m0_burstcount,
   input  logic [DATA_WIDTH-1:0]     m0_writedata,
   input  logic                      m0_read,
   input  logic                      m0_write,
   output logic                      m0_waitrequest,
   output logic [DATA_WIDTH-1:0]     m0_readdata,
   output logic                      m0_readdatavalid,
   input  logic [ADDR_WIDTH-1:0]     m1_address,
   input  logic [DATA_WIDTH/8-1:0]   m1_byteenable,
   input  logic [BURST_WIDTH-1:0]    m1_burstcount,
   input  logic [DATA_WIDTH-1:0]     m1_writedata,
   input  logic                      m1_read,
   input  logic                      m1_write,
   output logic                      m1_waitrequest,
   output logic [DATA_WIDTH-1:0]     m1_readdata,
   output logic                      m1_readdatavalid,
   output logic [ADDR_WIDTH-1:0]     s_address,
   output logic [DATA_WIDTH/8-1:0]   s_byteenable,
   output logic [BURST_WIDTH-1:0]    s_burstcount,
   output logic [DATA_WIDTH-1:0]     s_writedata,
   output logic                      s_read,
   output logic                      s_write,
   output logic                      s_beginbursttransfer,
   input  logic                      s_waitrequest,
   input  logic                      s_readdatavalid,
   input  logic [DATA_WIDTH-1:0]     s_readdata,
   output logic [1:0]                grant
);

   localparam int CW = BURST_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ_CMD  = 2'd2,
      ST_READ_DATA = 2'd3
   } state_t;

   state_t            state_q, state_nxt;
   logic [1:0]        grant_q, grant_nxt;
   logic [CW-1:0]     cnt_q, cnt_nxt;
   logic              wr_started_q, wr_started_nxt;
   logic              last_m1_q, last_m1_nxt;

   logic              req0, req1, tie_m1, win_m1, win_write;
   logic              sel_m1, sel_read, sel_write, fwd;
   logic [BURST_WIDTH-1:0] sel_burst;
   logic [CW-1:0]     sel_beats, wr_rem;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Round-robin favours whoever did not own the last transaction.
   assign tie_m1    = (FIXED_PRIORITY_M0 != 0) ? 1'b0 : ~last_m1_q;
   assign win_m1    = req1 & (~req0 | tie_m1);
   assign win_write = win_m1 ? m1_write : m0_write;

   assign sel_m1    = grant_q[1];
   assign sel_read  = sel_m1 ? m1_read  : m0_read;
   assign sel_write = sel_m1 ? m1_write : m0_write;
   assign sel_burst = sel_m1 ? m1_burstcount : m0_burstcount;
   assign sel_beats = (sel_burst == '0) ? CW'(1) : {1'b0, sel_burst};
   assign wr_rem    = wr_started_q ? (cnt_q - CW'(1)) : (sel_beats - CW'(1));

   assign s_address    = sel_m1 ? m1_address    : m0_address;
   assign s_byteenable = sel_m1 ? m1_byteenable : m0_byteenable;
   assign s_burstcount = sel_burst;
   assign s_writedata  = sel_m1 ? m1_writedata  : m0_writedata;

   assign fwd            = (state_q == ST_WRITE) || (state_q == ST_READ_CMD);
   assign m0_waitrequest = (fwd && grant_q[0]) ? s_waitrequest : 1'b1;
   assign m1_waitrequest = (fwd && grant_q[1]) ? s_waitrequest : 1'b1;

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = (state_q == ST_READ_DATA) && grant_q[0] && s_readdatavalid;
   assign m1_readdatavalid = (state_q == ST_READ_DATA) && grant_q[1] && s_readdatavalid;

   assign grant = grant_q;

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= 2'b00;
         cnt_q        <= '0;
         wr_started_q <= 1'b0;
         last_m1_q    <= 1'b1;
      end else begin
         state_q      <= state_nxt;
         grant_q      <= grant_nxt;
         cnt_q        <= cnt_nxt;
         wr_started_q <= wr_started_nxt;
         last_m1_q    <= last_m1_nxt;
      end
   end

   always_comb begin
      state_nxt            = state_q;
      grant_nxt            = grant_q;
      cnt_nxt              = cnt_q;
      wr_started_nxt       = wr_started_q;
      last_m1_nxt          = last_m1_q;
      s_read               = 1'b0;
      s_write              = 1'b0;
      s_beginbursttransfer = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               grant_nxt      = win_m1 ? 2'b10 : 2'b01;
               state_nxt      = win_write ? ST_WRITE : ST_READ_CMD;
               cnt_nxt        = '0;
               wr_started_nxt = 1'b0;
            end
         end
         ST_WRITE: begin
            s_write              = sel_write;
            s_beginbursttransfer = sel_write & ~wr_started_q;
            if (sel_write && !s_waitrequest) begin
               wr_started_nxt = 1'b1;
               cnt_nxt        = wr_rem;
               if (wr_rem == '0) begin
                  state_nxt   = ST_IDLE;
                  grant_nxt   = 2'b00;
                  last_m1_nxt = sel_m1;
               end
            end
         end
         ST_READ_CMD: begin
            s_read               = sel_read;
            s_beginbursttransfer = sel_read;
            if (sel_read && !s_waitrequest) begin
               cnt_nxt   = sel_beats;
               state_nxt = ST_READ_DATA;
            end
         end
         ST_READ_DATA: begin
            if (s_readdatavalid) begin
               cnt_nxt = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_nxt   = ST_IDLE;
                  grant_nxt   = 2'b00;
                  last_m1_nxt = sel_m1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

endmodule

// File: tb/tb_mfp_avalon_arbiter_2to1.sv
// Directed bench for the 2:1 Avalon arbiter; a round-robin and a fixed-priority instance share
// all master and slave inputs.
module tb_mfp_avalon_arbiter_2to1;

   logic        avm_clk = 1'b0;
   logic        avm_rst;
   logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, s_readdata;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic [2:0]  m0_burstcount, m1_burstcount;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic        s_waitrequest, s_readdatavalid;

   logic        rr_m0_waitrequest, rr_m0_readdatavalid, rr_m1_waitrequest, rr_m1_readdatavalid;
   logic [31:0] rr_m0_readdata, rr_m1_readdata, rr_s_address, rr_s_writedata;
   logic [3:0]  rr_s_byteenable;
   logic [2:0]  rr_s_burstcount;
   logic        rr_s_read, rr_s_write, rr_s_begin;
   logic [1:0]  rr_grant;

   logic        fp_m0_waitrequest, fp_m0_readdatavalid, fp_m1_waitrequest, fp_m1_readdatavalid;
   logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_s_address, fp_s_writedata;
   logic [3:0]  fp_s_byteenable;
   logic [2:0]  fp_s_burstcount;
   logic        fp_s_read, fp_s_write, fp_s_begin;
   logic [1:0]  fp_grant;

   int total = 0;
   int bad   = 0;

   always #5 avm_clk = ~avm_clk;

   mfp_avalon_arbiter_2to1 #(.FIXED_PRIORITY_M0(0)) u_rr (
      .avm_clk(avm_clk), .avm_rst(avm_rst),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
      .m0_writedata(m0_writedata), .m0_read(m0_read), .m0_write(m0_write),
      .m0_waitrequest(rr_m0_waitrequest), .m0_readdata(rr_m0_readdata),
      .m0_readdatavalid(rr_m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
      .m1_writedata(m1_writedata), .m1_read(m1_read), .m1_write(m1_write),
      .m1_waitrequest(rr_m1_waitrequest), .m1_readdata(rr_m1_readdata),
      .m1_readdatavalid(rr_m1_readdatavalid),
      .s_address(rr_s_address), .s_byteenable(rr_s_byteenable), .s_burstcount(rr_s_burstcount),
      .s_writedata(rr_s_writedata), .s_read(rr_s_read), .s_write(rr_s_write),
      .s_beginbursttransfer(rr_s_begin), .s_waitrequest(s_waitrequest),
      .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata), .grant(rr_grant)
   );

   mfp_avalon_arbiter_2to1 #(.FIXED_PRIORITY_M0(1)) u_fp (
      .avm_clk(avm_clk), .avm_rst(avm_rst),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
      .m0_writedata(m0_writedata), .m0_read(m0_read), .m0_write(m0_write),
      .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
      .m0_readdatavalid(fp_m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
      .m1_writedata(m1_writedata), .m1_read(m1_read), .m1_write(m1_write),
      .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
      .m1_readdatavalid(fp_m1_readdatavalid),
      .s_address(fp_s_address), .s_byteenable(fp_s_byteenable), .s_burstcount(fp_s_burstcount),
      .s_writedata(fp_s_writedata), .s_read(fp_s_read), .s_write(fp_s_write),
      .s_beginbursttransfer(fp_s_begin), .s_waitrequest(s_waitrequest),
      .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata), .grant(fp_grant)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge avm_clk);
      #1;
   endtask

   logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      avm_rst = 1'b1;
      m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
      m0_byteenable = 4'hF; m1_byteenable = 4'hF; m0_burstcount = '0; m1_burstcount = '0;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;

      // reset values
      nxt(); nxt();
      chk("rst_grant_rr", rr_grant, 2'b00);
      chk("rst_grant_fp", fp_grant, 2'b00);
      chk("rst_m0_wait", rr_m0_waitrequest, 1);
      chk("rst_m1_wait", rr_m1_waitrequest, 1);
      chk("rst_s_read", rr_s_read, 0);
      chk("rst_s_write", rr_s_write, 0);
      chk("rst_s_begin", rr_s_begin, 0);
      chk("rst_m0_rdv", rr_m0_readdatavalid, 0);
      avm_rst = 1'b0;

      // single read, m0 burst 4 at 0x100
      m0_read = 1; m0_address = 32'h100; m0_burstcount = 3'd4; s_waitrequest = 1;
      #1;
      chk("rd_idle_grant", rr_grant, 2'b00);
      chk("rd_idle_s_read", rr_s_read, 0);
      chk("rd_idle_m0_wait", rr_m0_waitrequest, 1);
      nxt();
      chk("rd_cmd_grant", rr_grant, 2'b01);
      chk("rd_cmd_s_read", rr_s_read, 1);
      chk("rd_cmd_begin", rr_s_begin, 1);
      chk("rd_cmd_addr", rr_s_address, 32'h100);
      chk("rd_cmd_burst", rr_s_burstcount, 3'd4);
      chk("rd_cmd_m0_wait", rr_m0_waitrequest, 1);
      chk("rd_cmd_m1_wait", rr_m1_waitrequest, 1);
      nxt();
      chk("rd_cmd_hold", rr_s_read, 1);
      nxt();
      s_waitrequest = 0;
      #1;
      chk("rd_cmd_accept_wait", rr_m0_waitrequest, 0);
      chk("rd_cmd_accept_begin", rr_s_begin, 1);
      nxt();
      m0_read = 0;
      for (int i = 0; i < 5; i++) begin
         s_readdatavalid = pat[i];
         s_readdata = 32'hD000_0000 + i;
         #1;
         chk("rd_data_s_read", rr_s_read, 0);
         chk("rd_data_grant", rr_grant, 2'b01);
         chk("rd_data_m0_wait", rr_m0_waitrequest, 1);
         chk("rd_data_m0_rdv", rr_m0_readdatavalid, pat[i]);
         chk("rd_data_m1_rdv", rr_m1_readdatavalid, 0);
         chk("rd_data_value", rr_m0_readdata, 32'hD000_0000 + i);
         chk("rd_data_fp_m0_rdv", fp_m0_readdatavalid, pat[i]);
         nxt();
      end
      s_readdatavalid = 0;
      #1;
      chk("rd_done_grant_rr", rr_grant, 2'b00);
      chk("rd_done_grant_fp", fp_grant, 2'b00);

      // reset during READ_DATA with three beats outstanding
      m0_read = 1; m0_address = 32'h200; m0_burstcount = 3'd3;
      nxt();
      chk("rst_mid_cmd", rr_s_read, 1);
      nxt();
      m0_read = 0;
      #1;
      chk("rst_mid_grant_before", rr_grant, 2'b01);
      avm_rst = 1'b1;
      #1;
      chk("rst_mid_grant_async", rr_grant, 2'b00);
      nxt();
      chk("rst_mid_grant_edge", rr_grant, 2'b00);
      chk("rst_mid_m0_wait", rr_m0_waitrequest, 1);
      chk("rst_mid_m1_wait", rr_m1_waitrequest, 1);
      avm_rst = 1'b0;
      s_readdatavalid = 1;
      #1;
      chk("rst_mid_m0_rdv", rr_m0_readdatavalid, 0);
      chk("rst_mid_m1_rdv", rr_m1_readdatavalid, 0);
      nxt();
      s_readdatavalid = 0;

      // both masters issue single writes continuously
      m0_write = 1; m0_burstcount = 3'd1; m0_writedata = 32'hAAAA_0000;
      m1_write = 1; m1_burstcount = 3'd1; m1_writedata = 32'hBBBB_0000;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("tie_idle_rr", rr_grant, 2'b00);
         chk("tie_idle_fp", fp_grant, 2'b00);
         chk("tie_idle_s_write", rr_s_write, 0);
         nxt();
         chk("tie_grant_rr", rr_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("tie_wdata_rr", rr_s_writedata, (i % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0000);
         chk("tie_s_write_rr", rr_s_write, 1);
         chk("tie_begin_rr", rr_s_begin, 1);
         chk("tie_grant_fp", fp_grant, 2'b01);
         chk("tie_m1_wait_fp", fp_m1_waitrequest, 1);
         chk("tie_wdata_fp", fp_s_writedata, 32'hAAAA_0000);
         nxt();
      end
      m0_write = 0;
      #1;
      chk("tie_m0off_idle", fp_grant, 2'b00);
      nxt();
      chk("tie_m1only_rr", rr_grant, 2'b10);
      chk("tie_m1only_fp", fp_grant, 2'b10);
      nxt();
      m1_write = 0;
      #1;
      chk("tie_end_idle", rr_grant, 2'b00);

      // m1 write burst of 3 with a two-cycle stall on beat 2
      m1_write = 1; m1_burstcount = 3'd3; m1_writedata = 32'h11;
      nxt();
      chk("wb_b1_grant", rr_grant, 2'b10);
      chk("wb_b1_write", rr_s_write, 1);
      chk("wb_b1_begin", rr_s_begin, 1);
      chk("wb_b1_data", rr_s_writedata, 32'h11);
      chk("wb_b1_wait", rr_m1_waitrequest, 0);
      nxt();
      m1_writedata = 32'h22; s_waitrequest = 1;
      #1;
      chk("wb_b2_stall_begin", rr_s_begin, 0);
      chk("wb_b2_stall_write", rr_s_write, 1);
      chk("wb_b2_stall_wait", rr_m1_waitrequest, 1);
      chk("wb_b2_stall_data", rr_s_writedata, 32'h22);
      chk("wb_b2_stall_burst", rr_s_burstcount, 3'd3);
      nxt();
      chk("wb_b2_stall2_wait", rr_m1_waitrequest, 1);
      chk("wb_b2_stall2_begin", rr_s_begin, 0);
      nxt();
      s_waitrequest = 0;
      #1;
      chk("wb_b2_accept_wait", rr_m1_waitrequest, 0);
      chk("wb_b2_accept_data", rr_s_writedata, 32'h22);
      nxt();
      m1_writedata = 32'h33;
      #1;
      chk("wb_b3_write", rr_s_write, 1);
      chk("wb_b3_begin", rr_s_begin, 0);
      chk("wb_b3_data", rr_s_writedata, 32'h33);
      chk("wb_b3_wait", rr_m1_waitrequest, 0);
      chk("wb_b3_grant_fp", fp_grant, 2'b10);
      nxt();
      m1_write = 0;
      #1;
      chk("wb_done_grant_rr", rr_grant, 2'b00);
      chk("wb_done_grant_fp", fp_grant, 2'b00);
      chk("wb_done_write", rr_s_write, 0);

      // stray readdatavalid in IDLE, then a burstcount=0 read
      s_readdatavalid = 1; s_readdata = 32'hEE;
      #1;
      chk("stray_m0_rdv", rr_m0_readdatavalid, 0);
      chk("stray_m1_rdv", rr_m1_readdatavalid, 0);
      nxt();
      s_readdatavalid = 0;
      m0_read = 1; m0_burstcount = 3'd0; m0_address = 32'h300;
      #1;
      chk("bc0_idle_grant", rr_grant, 2'b00);
      nxt();
      chk("bc0_cmd_read", rr_s_read, 1);
      chk("bc0_cmd_burst", rr_s_burstcount, 3'd0);
      chk("bc0_cmd_addr", rr_s_address, 32'h300);
      chk("bc0_cmd_wait", rr_m0_waitrequest, 0);
      nxt();
      m0_read = 0; s_readdatavalid = 1; s_readdata = 32'h55;
      #1;
      chk("bc0_beat_rdv", rr_m0_readdatavalid, 1);
      chk("bc0_beat_data", rr_m0_readdata, 32'h55);
      chk("bc0_beat_bcast", rr_m1_readdata, 32'h55);
      chk("bc0_beat_m1_rdv", rr_m1_readdatavalid, 0);
      nxt();
      s_readdatavalid = 0;
      #1;
      chk("bc0_done_grant_rr", rr_grant, 2'b00);
      chk("bc0_done_grant_fp", fp_grant, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
